fed_wb_ctrl: RTL and testbench
==============================

Name: fed_wb_ctrl

Overview:
- Sequencer directly downstream of the FFT/ENC/DENC datapath block.
- Accepts one issued special op (FFT, ENC, DENC) with a destination register and drives the 3-bit op select into the datapath.
- Waits out the datapath latency, captures the 19-bit result, and queues {rd, data} in a small FIFO.
- Presents queued results to the register-file write port through a valid/ready handshake.

Parameters:
- DATA_W, 19, result/data width.
- ADDR_W, 4, destination register address width.
- FFT_LAT, 4, cycles the FFT path needs before its output is valid (>=1).
- DEPTH, 4, result FIFO entries (power of two, >=2).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-low.
- issue_valid  input  1  issue request.
- issue_ready  output  1  issue accepted when valid&ready.
- issue_op  input  3  001=FFT, 100=ENC, 010=DENC; all others illegal.
- issue_rd  input  ADDR_W  destination register.
- fed_sel  output  3  op select to the datapath block.
- fed_data  input  DATA_W  datapath result.
- wb_valid  output  1  FIFO head valid.
- wb_ready  input  1  register file accepts the head.
- wb_addr  output  ADDR_W  head destination.
- wb_data  output  DATA_W  head data.
- busy  output  1  op in flight (state != IDLE).
- err_op  output  1  one-cycle pulse on an accepted illegal op.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; FIFO emptied (rd/wr pointers and count = 0).
  - fed_sel=0, busy=0, err_op=0, wb_valid=0, wb_addr=0, wb_data=0, counter=0.
  - Reset mid-operation discards the in-flight op and all queued entries; no partial writeback.
- FSM states: IDLE, WAIT.
- issue_ready = (state==IDLE) && (count<DEPTH). Purely combinational from registered state; does not depend on issue_valid.
- Accept in IDLE, cycle T:
  - Legal op: latch op and rd; load cnt = FFT_LAT-1 for FFT, 0 for ENC/DENC; go to WAIT.
  - Illegal op: err_op=1 during T+1, no FIFO push, stay IDLE.
- WAIT:
  - fed_sel = latched op (registered output, changes on the cycle after accept).
  - cnt != 0: decrement.
  - cnt == 0: push {rd, fed_data} at that clock edge, return to IDLE; fed_sel returns to 000 on the same edge.
- Latency from accept edge to wb_valid:
  - ENC/DENC: 2 cycles.
  - FFT: FFT_LAT+1 cycles.
- Outside WAIT, fed_sel=000, which forces the datapath output to zero.
- FIFO:
  - wb_valid = count!=0; wb_addr/wb_data driven from the head entry.
  - Pop when wb_valid && wb_ready.
  - Push and pop on the same edge: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - Overflow cannot occur: the only push source was admitted with count<DEPTH and count cannot rise while in flight.
  - When empty, wb_addr/wb_data hold their last popped value.
- Holding rules:
  - wb_valid high with wb_ready low: wb_addr/wb_data stable.
  - issue_ready low: issue_valid/op/rd are ignored.
- Only one op is in flight; back-to-back issue is accepted no earlier than the cycle after return to IDLE.
- busy = (state==WAIT).

Optional Feature:
- Macro: FED_WB_STATS_EN.
- Defined:
  - Adds output done_cnt[7:0]: increments on every FIFO push, saturates at 255.
  - Adds output stall_cnt[7:0]: increments on each cycle with wb_valid && !wb_ready, saturates at 255.
  - Both counters clear on reset.
- Not defined: ports and counters absent; all other behaviour is identical.

Test Plan:
- Reset, then ENC issue rd=3 at T with fed_data model = 19'h003AA when sel=100 -> fed_sel=100 during T+1, then wb_valid=1, wb_addr=3, wb_data=19'h003AA at T+2; busy=1 only during T+1.
- FFT issue rd=5, FFT_LAT=4, model returns 19'h01234 on the 4th WAIT cycle -> fed_sel=001 for exactly 4 cycles, wb_valid at T+5 with data 19'h01234.
- wb_ready held 0, issue 4 DENC ops rd=0..3 -> 4 entries queued, issue_ready=0 thereafter. Raise wb_ready -> pops in order rd 0,1,2,3 on consecutive cycles; issue_ready returns the cycle after the first pop.
- Illegal op 3'b111 issued -> err_op=1 for one cycle, no wb_valid, state stays IDLE, next legal op accepted next cycle.
- FFT in flight (cnt=2) with 2 entries queued, assert rst=0 for one edge -> wb_valid=0, busy=0, fed_sel=000 immediately after; no stale entry appears afterwards.
- Push and pop on the same edge with count=1 -> count stays 1, new head data correct; with FED_WB_STATS_EN, done_cnt matches total pushes and stall_cnt matches backpressured cycles.

Source files
------------

// File: rtl/fed_wb_ctrl.sv
// rtl/fed_wb_ctrl.sv - FFT/ENC/DENC op sequencer with writeback FIFO (optional stats: FED_WB_STATS_EN)
module fed_wb_ctrl #(
    parameter int DATA_W  = 19,
    parameter int ADDR_W  = 4,
    parameter int FFT_LAT = 4,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [2:0]        issue_op,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic [2:0]        fed_sel,
    input  logic [DATA_W-1:0] fed_data,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic              err_op
`ifdef FED_WB_STATS_EN
    ,
    output logic [7:0]        done_cnt,
    output logic [7:0]        stall_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (FFT_LAT > 1) ? $clog2(FFT_LAT) : 1;
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    localparam logic [2:0] OP_FFT  = 3'b001;
    localparam logic [2:0] OP_ENC  = 3'b100;
    localparam logic [2:0] OP_DENC = 3'b010;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] rd_q;
    logic [CNT_W-1:0]  cnt;

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_nxt;
    logic [ENT_W-1:0]  push_ent;
    logic [ENT_W-1:0]  head_nxt;

    logic accept;
    logic op_legal;
    logic load;
    logic push;
    logic pop;

    assign issue_ready = (state == IDLE) && (count < FULL);
    assign accept      = issue_valid && issue_ready;
    assign op_legal    = (issue_op == OP_FFT) || (issue_op == OP_ENC) || (issue_op == OP_DENC);
    assign busy        = (state == WAIT);
    assign wb_valid    = (count != '0);
    assign pop         = wb_valid && wb_ready;
    assign push_ent    = {rd_q, fed_data};

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept a legal op from IDLE, leave WAIT when the latency counter expires
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (accept && op_legal) begin
                    state_nxt = WAIT;
                    load      = 1'b1;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    push      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Op latch, latency counter, datapath select and illegal-op pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_q    <= '0;
            cnt     <= '0;
            fed_sel <= 3'b000;
            err_op  <= 1'b0;
        end else begin
            err_op <= accept && !op_legal;
            if (load) begin
                rd_q    <= issue_rd;
                fed_sel <= issue_op;
                cnt     <= (issue_op == OP_FFT) ? CNT_W'(FFT_LAT - 1) : '0;
            end else if (push) begin
                fed_sel <= 3'b000;
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Next pointer/count and the entry that will sit at the head after this edge
    always_comb begin
        rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
        count_nxt  = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        head_nxt   = (push && (count_nxt == (PTR_W+1)'(1))) ? push_ent : mem[rd_ptr_nxt];
    end

    // FIFO storage; entries are not cleared, the count decides validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_ent;
        end
    end

    // FIFO pointers, occupancy and registered head outputs (held when the FIFO drains)
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            if (count_nxt != '0) begin
                {wb_addr, wb_data} <= head_nxt;
            end
        end
    end

`ifdef FED_WB_STATS_EN
    // Saturating completion and writeback-stall counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            done_cnt  <= 8'd0;
            stall_cnt <= 8'd0;
        end else begin
            if (push && (done_cnt != 8'hFF)) begin
                done_cnt <= done_cnt + 8'd1;
            end
            if (wb_valid && !wb_ready && (stall_cnt != 8'hFF)) begin
                stall_cnt <= stall_cnt + 8'd1;
            end
        end
    end
`else
    // statistics counters not built
`endif

endmodule

// File: tb/tb_fed_wb_ctrl.sv
// tb/tb_fed_wb_ctrl.sv - self-checking bench for fed_wb_ctrl
module tb_fed_wb_ctrl;

    localparam int DATA_W  = 19;
    localparam int ADDR_W  = 4;
    localparam int FFT_LAT = 4;
    localparam int DEPTH   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              issue_valid = 1'b0;
    logic              issue_ready;
    logic [2:0]        issue_op = 3'b000;
    logic [ADDR_W-1:0] issue_rd = '0;
    logic [2:0]        fed_sel;
    logic [DATA_W-1:0] fed_data;
    logic              wb_valid;
    logic              wb_ready = 1'b0;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              busy;
    logic              err_op;
`ifdef FED_WB_STATS_EN
    logic [7:0]        done_cnt;
    logic [7:0]        stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    fed_wb_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .FFT_LAT(FFT_LAT),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_op   (issue_op),
        .issue_rd   (issue_rd),
        .fed_sel    (fed_sel),
        .fed_data   (fed_data),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .busy       (busy),
        .err_op     (err_op)
`ifdef FED_WB_STATS_EN
        ,
        .done_cnt   (done_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Datapath model: the result is only correct on the last cycle of the op's latency
    logic [DATA_W-1:0] dp_result = '0;
    int run = 0;
    always @(posedge clk) run <= (fed_sel != 3'b000) ? run + 1 : 0;
    assign fed_data = (fed_sel == 3'b000) ? '0 :
                      (run == ((fed_sel == 3'b001) ? FFT_LAT : 1) - 1) ? dp_result : ~dp_result;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [2:0] op, input logic [3:0] rd, input logic [18:0] res);
        int n;
        n = 0;
        while (!issue_ready && n < 30) begin
            step();
            n++;
        end
        if (n >= 30) begin
            checks++;
            errors++;
            $display("FAIL issue_wait: issue_ready stayed 0 for %0d cycles, required 1", n);
        end
        issue_valid = 1'b1;
        issue_op    = op;
        issue_rd    = rd;
        dp_result   = res;
        step();
        issue_valid = 1'b0;
    endtask

    function automatic bit is_legal(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b100) || (op == 3'b010);
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  rd;
        logic [18:0] res;
        int          lat;
        bit          err;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    // Reference model state
    logic [22:0] q[$];
    logic [22:0] m_last;
    bit          m_busy;
    bit          m_err;
    int          m_rem;
    logic [2:0]  m_op;
    logic [3:0]  m_rd;
    logic [18:0] m_res;
    int          m_done;
    int          m_stall;

    task automatic model_reset();
        q.delete();
        m_last  = '0;
        m_busy  = 1'b0;
        m_err   = 1'b0;
        m_rem   = 0;
        m_op    = 3'b000;
        m_rd    = '0;
        m_res   = '0;
        m_done  = 0;
        m_stall = 0;
    endtask

    initial begin
        int k;
        int selc;
        int stale;
        int pct;
        bit exp_ready;
        bit was_busy;
        logic [22:0] head;

        vecs[0] = '{op: 3'b100, rd: 4'd3,  res: 19'h003AA, lat: 2,           err: 1'b0};
        vecs[1] = '{op: 3'b001, rd: 4'd5,  res: 19'h01234, lat: FFT_LAT + 1, err: 1'b0};
        vecs[2] = '{op: 3'b010, rd: 4'd15, res: 19'h7FFFF, lat: 2,           err: 1'b0};
        vecs[3] = '{op: 3'b111, rd: 4'd1,  res: 19'h00055, lat: 0,           err: 1'b1};
        vecs[4] = '{op: 3'b000, rd: 4'd2,  res: 19'h00066, lat: 0,           err: 1'b1};
        vecs[5] = '{op: 3'b001, rd: 4'd0,  res: 19'h00001, lat: FFT_LAT + 1, err: 1'b0};
        vecs[6] = '{op: 3'b011, rd: 4'd9,  res: 19'h00077, lat: 0,           err: 1'b1};

        // Reset state
        rst = 1'b0;
        repeat (3) step();
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fed_sel", fed_sel, 0);
        chk("rst_err_op", err_op, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_issue_ready", issue_ready, 1);
        rst = 1'b1;

        // Single-op vectors: latency, select duration, result, illegal-op pulse
        for (int v = 0; v < NV; v++) begin
            wb_ready = 1'b1;
            step();
            step();
            chk($sformatf("vec%0d_ready", v), issue_ready, 1);
            issue_valid = 1'b1;
            issue_op    = vecs[v].op;
            issue_rd    = vecs[v].rd;
            dp_result   = vecs[v].res;
            step();
            issue_valid = 1'b0;
            chk($sformatf("vec%0d_err", v), err_op, vecs[v].err);
            chk($sformatf("vec%0d_busy", v), busy, !vecs[v].err);
            if (vecs[v].err) begin
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("vec%0d_no_wb", v), wb_valid, 0);
                    chk($sformatf("vec%0d_idle", v), busy, 0);
                    step();
                end
            end else begin
                k = 1;
                selc = 0;
                while (!wb_valid && k < 20) begin
                    if (fed_sel == vecs[v].op) selc++;
                    step();
                    k++;
                end
                chk($sformatf("vec%0d_latency", v), k, vecs[v].lat);
                chk($sformatf("vec%0d_sel_cycles", v), selc, vecs[v].lat - 1);
                chk($sformatf("vec%0d_wb_addr", v), wb_addr, vecs[v].rd);
                chk($sformatf("vec%0d_wb_data", v), wb_data, vecs[v].res);
                chk($sformatf("vec%0d_busy_done", v), busy, 0);
                chk($sformatf("vec%0d_sel_done", v), fed_sel, 0);
            end
        end
        step();

        // Illegal op followed by a legal op on the very next cycle
        wb_ready    = 1'b1;
        issue_valid = 1'b1;
        issue_op    = 3'b111;
        issue_rd    = 4'd4;
        step();
        chk("ill_err_pulse", err_op, 1);
        chk("ill_busy", busy, 0);
        chk("ill_ready", issue_ready, 1);
        issue_op  = 3'b100;
        issue_rd  = 4'd6;
        dp_result = 19'h00ABC;
        step();
        issue_valid = 1'b0;
        chk("ill_err_cleared", err_op, 0);
        chk("ill_next_busy", busy, 1);
        chk("ill_next_sel", fed_sel, 3'b100);
        step();
        chk("ill_next_wb_valid", wb_valid, 1);
        chk("ill_next_wb_addr", wb_addr, 6);
        chk("ill_next_wb_data", wb_data, 19'h00ABC);
        step();

        // Fill the FIFO under backpressure, then drain in order
        wb_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) do_issue(3'b010, 4'(i), 19'(32'h100 + i));
        step();
        chk("fill_wb_valid", wb_valid, 1);
        chk("fill_issue_ready", issue_ready, 0);
        issue_valid = 1'b1;
        issue_op    = 3'b100;
        issue_rd    = 4'd9;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fill_ignored_busy", busy, 0);
            chk("fill_ignored_ready", issue_ready, 0);
        end
        issue_valid = 1'b0;
        wb_ready    = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain%0d_valid", i), wb_valid, 1);
            chk($sformatf("drain%0d_addr", i), wb_addr, i);
            chk($sformatf("drain%0d_data", i), wb_data, 32'h100 + i);
            if (i == 0) chk("drain_ready_before_pop", issue_ready, 0);
            if (i == 1) chk("drain_ready_after_pop", issue_ready, 1);
            step();
        end
        chk("drain_empty", wb_valid, 0);
        chk("drain_hold_addr", wb_addr, DEPTH - 1);

        // Reset with an FFT in flight and two entries queued
        wb_ready = 1'b0;
        do_issue(3'b100, 4'd1, 19'h00011);
        do_issue(3'b100, 4'd2, 19'h00022);
        do_issue(3'b001, 4'd5, 19'h00055);
        step();
        chk("midrst_pre_valid", wb_valid, 1);
        chk("midrst_pre_busy", busy, 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_wb_valid", wb_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_fed_sel", fed_sel, 0);
        chk("midrst_wb_addr", wb_addr, 0);
        chk("midrst_wb_data", wb_data, 0);
        chk("midrst_ready", issue_ready, 1);
        wb_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            if (wb_valid) stale++;
            step();
        end
        chk("midrst_no_stale", stale, 0);

        // Push and pop on the same edge with one entry queued
        wb_ready = 1'b0;
        do_issue(3'b100, 4'd7, 19'h11111);
        step();
        chk("pp_one_entry", wb_valid, 1);
        do_issue(3'b100, 4'd8, 19'h22222);
        wb_ready = 1'b1;
        step();
        chk("pp_valid", wb_valid, 1);
        chk("pp_head_addr", wb_addr, 8);
        chk("pp_head_data", wb_data, 19'h22222);
        wb_ready = 1'b0;
        step();
        chk("pp_count_one", wb_valid, 1);
        wb_ready = 1'b1;
        step();
        chk("pp_drained", wb_valid, 0);
        chk("pp_hold_data", wb_data, 19'h22222);

        // Randomized run against the queue-based reference model
        rst = 1'b0;
        issue_valid = 1'b0;
        step();
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            exp_ready = !m_busy && (q.size() < DEPTH);
            head = (q.size() != 0) ? q[0] : m_last;
            chk("rnd_issue_ready", issue_ready, exp_ready);
            chk("rnd_busy", busy, m_busy);
            chk("rnd_fed_sel", fed_sel, m_busy ? m_op : 3'b000);
            chk("rnd_err_op", err_op, m_err);
            chk("rnd_wb_valid", wb_valid, q.size() != 0);
            chk("rnd_wb_head", {wb_addr, wb_data}, head);
`ifdef FED_WB_STATS_EN
            chk("rnd_done_cnt", done_cnt, (m_done > 255) ? 255 : m_done);
            chk("rnd_stall_cnt", stall_cnt, (m_stall > 255) ? 255 : m_stall);
`endif
            pct = (((c / 200) % 2) == 1) ? 20 : 85;
            rst = ($urandom_range(0, 149) != 0);
            wb_ready = ($urandom_range(0, 99) < pct);
            issue_valid = $urandom_range(0, 1);
            case ($urandom_range(0, 9))
                0, 1, 2: issue_op = 3'b001;
                3, 4, 5: issue_op = 3'b100;
                6, 7:    issue_op = 3'b010;
                default: issue_op = 3'($urandom_range(0, 7));
            endcase
            issue_rd = 4'($urandom);
            if (!m_busy) dp_result = 19'($urandom);

            @(posedge clk);
            if (!rst) begin
                model_reset();
            end else begin
                was_busy = m_busy;
                m_err = 1'b0;
                if (q.size() != 0 && !wb_ready) m_stall++;
                if (q.size() != 0 && wb_ready) m_last = q.pop_front();
                if (was_busy) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        q.push_back({m_rd, m_res});
                        m_busy = 1'b0;
                        m_done++;
                    end
                end
                if (exp_ready && issue_valid) begin
                    if (is_legal(issue_op)) begin
                        m_busy = 1'b1;
                        m_op   = issue_op;
                        m_rd   = issue_rd;
                        m_res  = dp_result;
                        m_rem  = (issue_op == 3'b001) ? FFT_LAT : 1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
